// File: rtl/gate_exerciser_pkg.sv
// gate_exerciser_pkg
//   Shared definitions for the gate exerciser: FSM state encoding and the
//   truth tables of the common two-input gates. Each table holds one bit per
//   input vector; bit k is the expected gate output when stim == k.
package gate_exerciser_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two-input truth tables, indexed by {b, a}.
  localparam logic [3:0] TT_OR2   = 4'b1110;
  localparam logic [3:0] TT_AND2  = 4'b1000;
  localparam logic [3:0] TT_NAND2 = 4'b0111;
  localparam logic [3:0] TT_XOR2  = 4'b0110;

endpackage

// File: rtl/gate_exerciser_hold_counter.sv
// hold_counter
//   Loadable down-counter that times how long each stimulus vector is held.
//   load has priority over en; the count stops at zero.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (count -> 0)
//   load      : load load_val on the next edge
//   load_val  : value to load
//   en        : decrement on the next edge (when not already zero)
//   zero      : count is zero
module hold_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_exerciser.sv
// gate_exerciser
//   Drives a combinational gate through every input combination, holds each
//   vector for HOLD_CYCLES clocks, samples the gate output on the last edge of
//   the hold window and compares it with the EXPECTED truth table.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a sweep (honoured in IDLE or DONE only)
//   abort             : synchronous return to IDLE, clears status
//   resp              : gate output under test (synchronous to clk)
//   stim              : vector driven to the gate inputs (bit 0 = a)
//   busy              : sweep in progress
//   done              : sweep complete, status valid
//   pass              : done with no mismatches
//   err_count         : number of mismatching vectors in the last sweep
//   first_fail_valid  : a mismatch has been recorded
//   first_fail_vec    : stim value of the first mismatch
//   fsm_state         : current FSM state, for observation
// Handshake: start and abort are level-sampled on each rising edge; there is
//   no ready/acknowledge, busy and done report progress.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int                N_IN        = 2,
  parameter int                HOLD_CYCLES = 4,
  parameter logic [2**N_IN-1:0] EXPECTED   = TT_OR2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic            resp,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec,
  output state_t          fsm_state
);

  localparam int              CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [N_IN-1:0] LAST_VEC  = '1;

  state_t            state_q, state_d;
  logic [N_IN-1:0]   stim_d;
  logic              busy_d, done_d;
  logic [N_IN:0]     err_count_d;
  logic              ffv_d;
  logic [N_IN-1:0]   ffvec_d;
  logic              cnt_load, cnt_en, cnt_zero;
  logic              mismatch;

  hold_counter #(.WIDTH(CW)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (HOLD_LOAD),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else begin
      state_q          <= state_d;
      stim             <= stim_d;
      busy             <= busy_d;
      done             <= done_d;
      err_count        <= err_count_d;
      first_fail_valid <= ffv_d;
      first_fail_vec   <= ffvec_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stim_d      = stim;
    busy_d      = busy;
    done_d      = done;
    err_count_d = err_count;
    ffv_d       = first_fail_valid;
    ffvec_d     = first_fail_vec;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    mismatch    = (resp != EXPECTED[stim]);

    if (abort) begin
      // Abort wins over start and over any compare due at this edge.
      state_d     = IDLE;
      stim_d      = '0;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      err_count_d = '0;
      ffv_d       = 1'b0;
      ffvec_d     = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d     = RUN;
            stim_d      = '0;
            cnt_load    = 1'b1;
            err_count_d = '0;
            ffv_d       = 1'b0;
            ffvec_d     = '0;
            busy_d      = 1'b1;
            done_d      = 1'b0;
          end
        end
        RUN: begin
          if (!cnt_zero) begin
            cnt_en = 1'b1;
          end else begin
            // Last edge of the hold window: sample and score this vector.
            if (mismatch) begin
              err_count_d = err_count + 1'b1;
              if (!first_fail_valid) begin
                ffv_d   = 1'b1;
                ffvec_d = stim;
              end
            end
            if (stim == LAST_VEC) begin
              state_d = DONE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
              stim_d  = '0;
            end else begin
              stim_d   = stim + 1'b1;
              cnt_load = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign pass      = done && (err_count == '0);
  assign fsm_state = state_q;

endmodule

// File: doc/gate_exerciser.md
Name: gate_exerciser

Overview:
- Self-checking stimulus/response stage that sits around a combinational gate block (e.g. OR-from-NAND).
- Drives the gate's inputs through every input combination, holds each vector for a settle window, samples the gate output and compares it against a parameterised truth table.
- Replaces hand-written initial-block stimulus with a reusable, clocked exerciser that produces a pass/fail verdict.

Parameters:
- N_IN, 2, number of gate inputs driven; legal range 1..4.
- HOLD_CYCLES, 4, clocks each vector is held before sampling; must be >= 1.
- EXPECTED, 4'b1110, expected truth table, width 2**N_IN. Bit k is the expected output for stim==k. The default is OR.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE or DONE.
- abort  in  1  synchronous return to IDLE; status is cleared.
- resp  in  1  gate output under test.
- stim  out  N_IN  vector driven to the gate inputs (bit 0 = input a, bit 1 = input b).
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep completion until the next start, abort or reset.
- pass  out  1  done && err_count==0.
- err_count  out  N_IN+1  number of mismatching vectors in the last sweep.
- first_fail_valid  out  1  at least one mismatch has been recorded.
- first_fail_vec  out  N_IN  stim value of the first mismatch.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (asynchronous, takes effect immediately, including mid-sweep): state=IDLE, and all outputs are 0.
- IDLE -> RUN on a clock edge with start=1 (and abort=0).
  - At that edge: stim<=0, hold counter cnt<=HOLD_CYCLES-1, err_count<=0, first_fail_valid<=0, first_fail_vec<=0, busy<=1, done<=0.
- RUN, each edge:
  - If cnt!=0: cnt decrements and stim holds.
  - If cnt==0: resp is compared to EXPECTED[stim].
    - On mismatch, err_count increments. If first_fail_valid==0, first_fail_vec<=stim and first_fail_valid<=1.
    - Then, if stim==2**N_IN-1: state<=DONE, busy<=0, done<=1, stim<=0.
    - Otherwise: stim<=stim+1 and cnt<=HOLD_CYCLES-1.
- Latency and timing:
  - Each vector is driven for exactly HOLD_CYCLES clocks.
  - resp is sampled at the final edge of each hold window.
  - done rises at edge number 2**N_IN*HOLD_CYCLES after the start edge. The defaults give 16.
  - err_count, first_fail_* and pass are valid in the same cycle done rises, including the last vector's compare.
- DONE:
  - All status outputs hold.
  - start=1 behaves exactly as start in IDLE: a new sweep begins and status is cleared.
- start while busy: ignored, with no restart and no status change.
- abort: has priority over start and over the compare.
  - From any state: state<=IDLE, and stim, busy, done, err_count and first_fail_* are cleared.
  - Takes effect at the next edge. No compare occurs at that edge.
- Outside RUN, stim is 0. stim never exceeds 2**N_IN-1 and never wraps inside a sweep.
- err_count cannot overflow, since its maximum is 2**N_IN and it is N_IN+1 bits wide.
- HOLD_CYCLES==1: cnt is always 0, and one vector is compared per clock.
- resp is treated as already synchronous to clk, because the gate is combinational from stim. The block has no internal synchroniser.

Decomposition:
- gate_exerciser_pkg holds:
  - the state encoding localparams: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the constant for the default OR table, 4'b1110;
  - constants for the AND, NAND and XOR tables, for reuse across sibling benches.
- One sub-module is natural: hold_counter.
  - Loadable down-counter of width $clog2(HOLD_CYCLES) (minimum 1) with load, en and zero outputs.
  - Uses the same clk and asynchronous active-high rst.

Test Plan:
- Correct OR DUT, defaults, start pulsed at edge 0 -> stim goes 0,1,2,3, each held 4 clocks; done=1 at edge 16; pass=1, err_count=0, first_fail_valid=0.
- resp tied to 0, EXPECTED=4'b1110 -> done at edge 16, err_count=3, first_fail_vec=2'b01, pass=0.
- Correct OR DUT, start pulsed again at edge 8 (mid-sweep) -> ignored; done still at edge 16 with pass=1.
- abort at edge 6 -> busy=0, stim=0, done=0 at edge 7. A subsequent start yields a full fresh sweep with err_count=0.
- rst asserted asynchronously at edge 9.5 -> all outputs 0 immediately. After release and start, the sweep completes normally.
- HOLD_CYCLES=1, N_IN=3, EXPECTED=8'b1000_0000 (3-input AND), correct DUT -> done at edge 8, pass=1. With resp inverted: err_count=8 and first_fail_vec=3'b000.
